// File: rtl/alu_wb_if.sv
// Writeback-stage bundle: ALU result + sideband in,
// shared RF write port and fetch redirect out.
interface alu_wb_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int PC_W   = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_result;
    logic              in_cond;
    logic [REG_W-1:0]  in_rd;
    logic              in_rd_we;
    logic [1:0]        in_br;
    logic              in_link;
    logic [PC_W-1:0]   in_target;
    logic [PC_W-1:0]   in_pc_next;
    logic              in_epoch;
    logic              rf_ready;
    logic              rf_we;
    logic [REG_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              redirect;
    logic [PC_W-1:0]   redirect_pc;
    logic              epoch;

    modport master (
        output in_valid, in_result, in_cond, in_rd, in_rd_we,
        output in_br, in_link, in_target, in_pc_next, in_epoch,
        output rf_ready,
        input  in_ready, rf_we, rf_waddr, rf_wdata,
        input  redirect, redirect_pc, epoch
    );

    modport slave (
        input  in_valid, in_result, in_cond, in_rd, in_rd_we,
        input  in_br, in_link, in_target, in_pc_next, in_epoch,
        input  rf_ready,
        output in_ready, rf_we, rf_waddr, rf_wdata,
        output redirect, redirect_pc, epoch
    );
endinterface

// File: rtl/alu_wb.sv
// Writeback / branch-resolve stage: epoch-based kill, one-cycle
// redirect pulse, 2-entry in-order RF write buffer.
module alu_wb #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int PC_W   = 16
) (
    input logic     clk,
    input logic     rst_b,
    alu_wb_if.slave wb
);
    typedef struct packed {
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t            mem_q [2];
    logic [1:0]      cnt_q, cnt_d;
    logic            rp_q, rp_d;
    logic            wp_q, wp_d;
    logic            epoch_q, epoch_d;
    logic            redir_q, redir_d;
    logic [PC_W-1:0] rpc_q, rpc_d;
    logic            rdy_q, rdy_d;

    logic              acc, live, taken;
    logic              push, pop;
    logic [DATA_W-1:0] pc_ext;
    ent_t              ent;

    generate
        if (PC_W >= DATA_W) begin : g_trunc
            assign pc_ext = wb.in_pc_next[DATA_W-1:0];
        end else begin : g_zext
            assign pc_ext = {{(DATA_W-PC_W){1'b0}}, wb.in_pc_next};
        end
    endgenerate

    always_comb begin
        acc   = wb.in_valid & rdy_q;
        live  = acc & (wb.in_epoch == epoch_q);
        taken = 1'b0;
        unique case (wb.in_br)
            2'b01:   taken = wb.in_cond;
            2'b10:   taken = ~wb.in_cond;
            2'b11:   taken = 1'b1;
            default: taken = 1'b0;
        endcase
        push     = live & wb.in_rd_we & (|wb.in_rd);
        pop      = (cnt_q != 2'd0) & wb.rf_ready;
        ent.rd   = wb.in_rd;
        ent.data = wb.in_link ? pc_ext : wb.in_result;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        rp_d     = rp_q ^ pop;
        wp_d     = wp_q ^ push;
        rdy_d    = ~cnt_d[1];
        redir_d  = live & taken;
        epoch_d  = epoch_q ^ redir_d;
        rpc_d    = redir_d ? wb.in_target : rpc_q;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cnt_q   <= '0;
            rp_q    <= 1'b0;
            wp_q    <= 1'b0;
            epoch_q <= 1'b0;
            redir_q <= 1'b0;
            rpc_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            epoch_q <= epoch_d;
            redir_q <= redir_d;
            rpc_q   <= rpc_d;
            rdy_q   <= rdy_d;
        end
    end

    // Payload storage needs no reset: cnt_q gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wp_q] <= ent;
        end
    end

    assign wb.in_ready    = rdy_q;
    assign wb.rf_we       = (cnt_q != 2'd0);
    assign wb.rf_waddr    = mem_q[rp_q].rd;
    assign wb.rf_wdata    = mem_q[rp_q].data;
    assign wb.redirect    = redir_q;
    assign wb.redirect_pc = rpc_q;
    assign wb.epoch       = epoch_q;
endmodule

// File: tb/tb_alu_wb.sv
// Randomized + directed bench for alu_wb against a
// transaction-level model (write queue, epoch, redirect).
module tb_alu_wb;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int PW = 16;

    logic clk = 1'b0;
    logic rst_b = 1'b0;

    alu_wb_if #(.DATA_W(DW), .REG_W(RW), .PC_W(PW)) wb ();

    alu_wb #(.DATA_W(DW), .REG_W(RW), .PC_W(PW)) dut (
        .clk  (clk),
        .rst_b(rst_b),
        .wb   (wb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        cond;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  br;
        logic        link;
        logic [15:0] tgt;
        logic [15:0] pcn;
        logic        ep;
    } ins_t;

    int checks = 0;
    int fails = 0;

    logic [36:0] q[$];
    logic        m_ep;
    logic        m_rdr;
    logic        m_rdy;
    logic [15:0] m_rpc;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ep  = 1'b0;
        m_rdr = 1'b0;
        m_rdy = 1'b0;
        m_rpc = '0;
    endtask

    function automatic ins_t nop();
        ins_t i;
        i.res  = '0;
        i.cond = 1'b0;
        i.rd   = '0;
        i.we   = 1'b0;
        i.br   = 2'b00;
        i.link = 1'b0;
        i.tgt  = '0;
        i.pcn  = '0;
        i.ep   = m_ep;
        return i;
    endfunction

    function automatic ins_t rnd();
        ins_t i;
        i.res  = $urandom;
        i.cond = 1'($urandom % 2);
        i.rd   = 5'($urandom % 32);
        i.we   = ($urandom % 4) != 0;
        i.br   = 2'($urandom % 4);
        i.link = ($urandom % 4) == 0;
        i.tgt  = 16'($urandom);
        i.pcn  = 16'($urandom);
        i.ep   = (($urandom % 8) == 0) ? ~m_ep : m_ep;
        return i;
    endfunction

    task automatic drive(ins_t i, logic v);
        wb.in_valid   = v;
        wb.in_result  = i.res;
        wb.in_cond    = i.cond;
        wb.in_rd      = i.rd;
        wb.in_rd_we   = i.we;
        wb.in_br      = i.br;
        wb.in_link    = i.link;
        wb.in_target  = i.tgt;
        wb.in_pc_next = i.pcn;
        wb.in_epoch   = i.ep;
    endtask

    // Called at a negedge with inputs set; returns at the next negedge.
    task automatic cycle(output bit acc);
        bit          live, tk, pop, wr;
        logic [31:0] d;
        logic [4:0]  rd;
        logic [15:0] tgt;
        check("in_ready", wb.in_ready, m_rdy);
        check("rf_we", wb.rf_we, q.size() != 0);
        if (q.size() != 0) begin
            check("rf_waddr", wb.rf_waddr, q[0][36:32]);
            check("rf_wdata", wb.rf_wdata, q[0][31:0]);
        end
        check("redirect", wb.redirect, m_rdr);
        if (m_rdr) check("redirect_pc", wb.redirect_pc, m_rpc);
        check("epoch", wb.epoch, m_ep);
        acc  = wb.in_valid && m_rdy && rst_b;
        live = acc && (wb.in_epoch == m_ep);
        tk   = (wb.in_br == 2'b11) ||
               (wb.in_br == 2'b01 && wb.in_cond) ||
               (wb.in_br == 2'b10 && !wb.in_cond);
        pop  = (q.size() != 0) && wb.rf_ready;
        wr   = live && wb.in_rd_we && (wb.in_rd != 0);
        d    = wb.in_link ? 32'(wb.in_pc_next) : wb.in_result;
        rd   = wb.in_rd;
        tgt  = wb.in_target;
        @(posedge clk);
        if (!rst_b) begin
            model_reset();
        end else begin
            if (pop) void'(q.pop_front());
            if (wr) q.push_back({rd, d});
            m_rdr = live && tk;
            if (m_rdr) begin
                m_rpc = tgt;
                m_ep  = ~m_ep;
            end
            m_rdy = q.size() < 2;
        end
        @(negedge clk);
    endtask

    task automatic idle(int n);
        bit acc;
        wb.in_valid = 1'b0;
        for (int k = 0; k < n; k++) cycle(acc);
    endtask

    task automatic send(ins_t i);
        bit acc;
        acc = 1'b0;
        drive(i, 1'b1);
        for (int k = 0; k < 20; k++) begin
            cycle(acc);
            if (acc) break;
        end
        check("send_accept", acc, 1'b1);
        wb.in_valid = 1'b0;
    endtask

    ins_t i;
    ins_t p;
    bit   have;
    bit   acc;

    initial begin
        model_reset();
        drive(nop(), 1'b0);
        wb.rf_ready = 1'b1;
        rst_b = 1'b0;
        @(negedge clk);
        idle(2);
        check("redirect_pc_rst", wb.redirect_pc, 16'h0);
        rst_b = 1'b1;
        idle(2);

        // 1: simple ALU write
        i = nop(); i.rd = 5'd3; i.we = 1'b1; i.res = 32'h1234;
        send(i);
        idle(2);

        // 2: taken branch, then stale-epoch write is killed
        i = nop(); i.br = 2'b01; i.cond = 1'b1; i.tgt = 16'h0040;
        send(i);
        i = nop(); i.ep = 1'b0; i.rd = 5'd5; i.we = 1'b1; i.res = 32'h55;
        send(i);
        idle(2);

        // 3: not-taken branch, then linking jump
        i = nop(); i.br = 2'b10; i.cond = 1'b1; i.tgt = 16'h0100;
        send(i);
        i = nop(); i.br = 2'b11; i.link = 1'b1; i.rd = 5'd31;
        i.we = 1'b1; i.pcn = 16'h0011; i.tgt = 16'h0080;
        send(i);
        idle(2);

        // 4: back-pressure with three writes
        wb.rf_ready = 1'b0;
        i = nop(); i.rd = 5'd1; i.we = 1'b1; i.res = 32'hA1;
        send(i);
        i = nop(); i.rd = 5'd2; i.we = 1'b1; i.res = 32'hA2;
        send(i);
        i = nop(); i.rd = 5'd4; i.we = 1'b1; i.res = 32'hA3;
        drive(i, 1'b1);
        cycle(acc);
        cycle(acc);
        wb.rf_ready = 1'b1;
        send(i);
        idle(4);

        // 5: r0 and non-writing instructions
        i = nop(); i.rd = 5'd0; i.we = 1'b1; i.res = 32'hDEAD;
        send(i);
        i = nop(); i.rd = 5'd7; i.we = 1'b0; i.res = 32'hBEEF;
        send(i);
        idle(2);

        // 6: reset with buffered writes and pending redirect
        wb.rf_ready = 1'b0;
        i = nop(); i.rd = 5'd8; i.we = 1'b1; i.res = 32'h88;
        send(i);
        i = nop(); i.br = 2'b11; i.link = 1'b1; i.rd = 5'd9;
        i.we = 1'b1; i.pcn = 16'h0200; i.tgt = 16'h0300;
        send(i);
        rst_b = 1'b0;
        #1;
        check("rst_rf_we", wb.rf_we, 1'b0);
        check("rst_redirect", wb.redirect, 1'b0);
        check("rst_epoch", wb.epoch, 1'b0);
        check("rst_in_ready", wb.in_ready, 1'b0);
        model_reset();
        @(negedge clk);
        wb.rf_ready = 1'b1;
        idle(2);
        rst_b = 1'b1;
        idle(4);

        // random traffic with held-until-accepted upstream
        have = 1'b0;
        p = nop();
        for (int it = 0; it < 400; it++) begin
            wb.rf_ready = ($urandom % 4) != 0;
            if (!have && ($urandom % 3) != 0) begin
                p = rnd();
                have = 1'b1;
            end
            drive(p, have);
            cycle(acc);
            if (acc) have = 1'b0;
        end
        wb.rf_ready = 1'b1;
        idle(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
